// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  // Canonical no-op (addi x0, x0, 0) for consumers that need a filler word.
  localparam logic [ILEN-1:0] INSTR_NOP = 32'h0000_0013;

  // One instruction-queue entry: fetch address plus the returned word.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  // Force an address onto a word boundary (low two bits cleared).
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~(XLEN'(3));
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction queue: circular buffer with a combinational head read.
// Flush wins over push and pop. While empty the head outputs keep showing the
// last entry that was at the head, so decode sees stable values.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  fetch_entry_t            push_entry,
  input  logic                    pop,
  input  logic                    flush,
  output fetch_entry_t            head,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  fetch_entry_t  last_head;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW + 1)'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  // A push into a full queue is only accepted when the head leaves the same cycle.
  assign do_push = push && !flush && (!full || do_pop);
  assign head    = empty ? last_head : mem[rd_ptr];

  // Storage write; contents are only observed through valid pointers.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW + 1)'(1);
        2'b01:   count <= count - (PW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Remember the currently displayed head so it can be held once the queue drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_head <= '0;
    end else if (!empty) begin
      last_head <= mem[rd_ptr];
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC generation, fixed-latency imem request
// tracking, credit-based issue and redirect flushing, feeding decode via a
// valid/ready instruction queue.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          IMEM_LAT   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);

  localparam int            CW           = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]   CREDIT_LIMIT = (CW + 1)'(FIFO_DEPTH);

  logic [31:0]   pc_reg;
  logic [31:0]   fetch_addr;
  logic          issue;
  logic          stage_valid [IMEM_LAT];
  logic [31:0]   stage_pc    [IMEM_LAT];
  logic [CW-1:0] inflight_count;
  logic [CW-1:0] queue_count;
  logic [CW:0]   credit_used;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  fetch_entry_t  push_entry;
  fetch_entry_t  head_entry;

  // A redirect overrides the sequential PC in the same cycle it arrives.
  assign fetch_addr = redirect_valid ? word_align(redirect_pc) : pc_reg;
  assign imem_addr  = fetch_addr;

  // Count requests still travelling through imem.
  always_comb begin
    inflight_count = '0;
    for (int i = 0; i < IMEM_LAT; i++) begin
      inflight_count = inflight_count + CW'(stage_valid[i]);
    end
  end

  // Every issued request owns a queue slot before it returns, so pushes never
  // overflow. Pops this cycle are deliberately not credited to keep timing short.
  assign credit_used = {1'b0, queue_count} + {1'b0, inflight_count};
  assign issue       = redirect_valid || (!fifo_full && (credit_used < CREDIT_LIMIT));

  // PC register: advance past the address just issued, wrapping at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg <= RESET_PC;
    end else if (issue) begin
      pc_reg <= fetch_addr + 32'd4;
    end
  end

  // In-flight tracker: stage 0 takes this cycle's request, later stages shift;
  // a redirect kills every older request but keeps the new stage-0 entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IMEM_LAT; i++) begin
        stage_valid[i] <= 1'b0;
        stage_pc[i]    <= '0;
      end
    end else begin
      stage_valid[0] <= issue;
      stage_pc[0]    <= fetch_addr;
      for (int i = 1; i < IMEM_LAT; i++) begin
        stage_valid[i] <= stage_valid[i-1] && !redirect_valid;
        stage_pc[i]    <= stage_pc[i-1];
      end
    end
  end

  // A word returning during a redirect belongs to the old path and is dropped.
  assign fifo_push  = stage_valid[IMEM_LAT-1] && !redirect_valid;
  assign push_entry = '{pc: stage_pc[IMEM_LAT-1], instr: imem_data};
  assign fifo_pop   = out_valid && out_ready;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (fifo_push),
    .push_entry (push_entry),
    .pop        (fifo_pop),
    .flush      (redirect_valid),
    .head       (head_entry),
    .count      (queue_count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_pc    = head_entry.pc;
  assign out_instr = head_entry.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a 2-cycle-latency imem model.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (4),
    .IMEM_LAT   (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
  );

  // imem contents: word i (at byte address 4i) is i tagged with a constant.
  function automatic logic [31:0] imem_word(input logic [31:0] addr);
    return {2'b00, addr[31:2]} ^ 32'hC0DE_0000;
  endfunction

  // imem: data for the address seen two rising edges ago.
  logic [31:0] addr_d1 = '0;
  logic [31:0] addr_d2 = '0;
  always @(posedge clk) begin
    addr_d1 <= imem_addr;
    addr_d2 <= addr_d1;
  end
  assign imem_data = imem_word(addr_d2);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          restart;
    bit          ready;
    bit          redir;
    logic [31:0] redir_pc;
    logic [31:0] exp_addr;
    bit          exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t vec[$];

  // rstv: head outputs still at their reset value (pc 0, instr 0).
  task automatic add(input bit restart, input bit ready, input bit redir, input logic [31:0] rpc,
                     input logic [31:0] addr, input bit valid, input logic [31:0] pc, input bit rstv);
    vec_t v;
    v.restart   = restart;
    v.ready     = ready;
    v.redir     = redir;
    v.redir_pc  = rpc;
    v.exp_addr  = addr;
    v.exp_valid = valid;
    v.exp_pc    = pc;
    v.exp_instr = rstv ? 32'h0 : imem_word(pc);
    vec.push_back(v);
  endtask

  // Hold reset for a few edges, then release just after a rising edge (cycle 0).
  task automatic reset_dut();
    rst_n          = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Collect n accepted outputs starting at first_pc, consecutive and within a cycle budget.
  task automatic collect(input string name, input logic [31:0] first_pc, input int n);
    logic [31:0] exp_pc;
    int got;
    exp_pc = first_pc;
    got    = 0;
    for (int cyc = 0; cyc < 20 && got < n; cyc++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        check($sformatf("%s pc%0d", name, got), out_pc, exp_pc);
        check($sformatf("%s instr%0d", name, got), out_instr, imem_word(exp_pc));
        $display("%s: accepted pc=%h instr=%h", name, out_pc, out_instr);
        exp_pc = exp_pc + 32'd4;
        got++;
      end else if (got > 0) begin
        check($sformatf("%s gap after %0d", name, got), 32'(out_valid), 32'd1);
      end
    end
    if (got < n) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got %0d outputs, required %0d", name, got, n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Stream from reset with out_ready=1, then redirect to 0x103 in cycle 10.
    add(1, 1, 0, 0, 32'h000, 0, 32'h000, 1);
    add(0, 1, 0, 0, 32'h004, 0, 32'h000, 1);
    add(0, 1, 0, 0, 32'h008, 0, 32'h000, 1);
    add(0, 1, 0, 0, 32'h00C, 1, 32'h000, 0);
    add(0, 1, 0, 0, 32'h010, 1, 32'h004, 0);
    add(0, 1, 0, 0, 32'h014, 1, 32'h008, 0);
    add(0, 1, 0, 0, 32'h018, 1, 32'h00C, 0);
    add(0, 1, 0, 0, 32'h01C, 1, 32'h010, 0);
    add(0, 1, 0, 0, 32'h020, 1, 32'h014, 0);
    add(0, 1, 0, 0, 32'h024, 1, 32'h018, 0);
    add(0, 1, 1, 32'h103, 32'h100, 1, 32'h01C, 0);
    add(0, 1, 0, 0, 32'h104, 0, 32'h01C, 0);
    add(0, 1, 0, 0, 32'h108, 0, 32'h01C, 0);
    add(0, 1, 0, 0, 32'h10C, 1, 32'h100, 0);
    add(0, 1, 0, 0, 32'h110, 1, 32'h104, 0);
    add(0, 1, 0, 0, 32'h114, 1, 32'h108, 0);
    // Backpressure from cycle 0: queue fills with 0x0-0xC, fetch stalls at 0x10.
    add(1, 0, 0, 0, 32'h000, 0, 32'h000, 1);
    add(0, 0, 0, 0, 32'h004, 0, 32'h000, 1);
    add(0, 0, 0, 0, 32'h008, 0, 32'h000, 1);
    add(0, 0, 0, 0, 32'h00C, 1, 32'h000, 0);
    add(0, 0, 0, 0, 32'h010, 1, 32'h000, 0);
    add(0, 0, 0, 0, 32'h010, 1, 32'h000, 0);
    add(0, 0, 0, 0, 32'h010, 1, 32'h000, 0);
    add(0, 0, 0, 0, 32'h010, 1, 32'h000, 0);
    add(0, 1, 0, 0, 32'h010, 1, 32'h000, 0);
    add(0, 1, 0, 0, 32'h010, 1, 32'h004, 0);
    add(0, 1, 0, 0, 32'h014, 1, 32'h008, 0);
    add(0, 1, 0, 0, 32'h018, 1, 32'h00C, 0);
    add(0, 1, 0, 0, 32'h01C, 1, 32'h010, 0);
    add(0, 1, 0, 0, 32'h020, 1, 32'h014, 0);
    add(0, 1, 0, 0, 32'h024, 1, 32'h018, 0);

    foreach (vec[i]) begin
      if (vec[i].restart) begin
        reset_dut();
      end else begin
        @(posedge clk);
        #1;
      end
      out_ready      = vec[i].ready;
      redirect_valid = vec[i].redir;
      redirect_pc    = vec[i].redir_pc;
      @(negedge clk);
      $display("vec %0d: addr=%h valid=%0d pc=%h instr=%h", i, imem_addr, out_valid, out_pc, out_instr);
      check($sformatf("vec%0d imem_addr", i), imem_addr, vec[i].exp_addr);
      check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vec[i].exp_valid));
      check($sformatf("vec%0d out_pc", i), out_pc, vec[i].exp_pc);
      check($sformatf("vec%0d out_instr", i), out_instr, vec[i].exp_instr);
    end

    // Redirect while the head is being popped: pop ignored, queue flushed.
    @(posedge clk);
    #1 out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0202;
    @(negedge clk);
    check("redir_pop addr", imem_addr, 32'h0000_0200);
    check("redir_pop head_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    @(negedge clk);
    check("redir_pop valid_r1", 32'(out_valid), 32'd0);
    check("redir_pop addr_r1", imem_addr, 32'h0000_0204);
    collect("redir_pop", 32'h0000_0200, 3);

    // PC wrap across 2^32.
    @(posedge clk);
    #1 redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    @(negedge clk);
    check("wrap addr", imem_addr, 32'hFFFF_FFF8);
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    @(negedge clk);
    check("wrap addr_r1", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    check("wrap addr_r2", imem_addr, 32'h0000_0000);
    collect("wrap", 32'hFFFF_FFF8, 3);

    // Asynchronous reset with a partially filled queue.
    @(posedge clk);
    #1 out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("pre_rst valid", 32'(out_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst valid", 32'(out_valid), 32'd0);
    check("async_rst addr", imem_addr, 32'h0000_0000);
    check("async_rst pc", out_pc, 32'h0000_0000);
    check("async_rst instr", out_instr, 32'h0000_0000);
    @(posedge clk);
    #1 rst_n = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      $display("restart cycle %0d: addr=%h valid=%0d pc=%h", c, imem_addr, out_valid, out_pc);
      check($sformatf("restart c%0d addr", c), imem_addr, 32'(4 * c));
      check($sformatf("restart c%0d valid", c), 32'(out_valid), (c >= 3) ? 32'd1 : 32'd0);
      if (c >= 3) begin
        check($sformatf("restart c%0d pc", c), out_pc, 32'(4 * (c - 3)));
        check($sformatf("restart c%0d instr", c), out_instr, imem_word(32'(4 * (c - 3))));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end that drives `imem`. It generates the PC, issues one word address per cycle into the fixed 2-cycle-latency instruction memory, and tracks in-flight requests.
- Returned words are captured with their PCs in a small instruction queue that feeds decode through a valid/ready handshake.
- Handles redirects from branches and jumps by flushing in-flight and queued instructions.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 4, instruction queue entries. Power of 2, >= IMEM_LAT+2.
- IMEM_LAT, 2, cycles from imem_addr driven to imem_data valid. Fixed to match imem.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- imem_addr  out  32  byte address to imem, driven every cycle, word aligned
- imem_data  in  32  imem read data; word for the address driven IMEM_LAT cycles earlier
- redirect_valid  in  1  pipeline redirect request (branch/jump/trap)
- redirect_pc  in  32  redirect target; bits [1:0] ignored (treated as 0)
- out_valid  out  1  queue head holds a valid instruction
- out_ready  in  1  decode accepts the head this cycle
- out_pc  out  32  PC of the head instruction
- out_instr  out  32  head instruction word

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low (rst_n); all state clears immediately on assertion.
- Reset values:
  - pc = RESET_PC; in-flight valid bits = 0; queue empty.
  - out_valid = 0; out_pc = 0; out_instr = 0; imem_addr = RESET_PC.
- imem has no enable, so an address is presented every cycle.
- In-flight tracker: an IMEM_LAT-deep shift register of {valid, pc}.
  - Stage 0 is loaded each cycle with {issue, imem_addr}.
  - When the last stage is valid, {pc, imem_data} is pushed into the queue at the end of that cycle.
- Issue rule:
  - issue = (queue_count + inflight_count) < FIFO_DEPTH, using registered counts. A pop in the same cycle is not credited.
  - On issue: pc <= imem_addr + 4, modulo 2^32, so 0xFFFF_FFFC wraps to 0.
  - On no issue: imem_addr holds the current pc and stage 0 gets valid = 0 (bubble).
- Latency and throughput:
  - Address driven in cycle t → word pushed at end of cycle t+2 → out_valid in cycle t+3.
  - First out_valid is in the third cycle after rst_n deasserts, with out_pc = RESET_PC.
  - Sustained throughput is 1 instruction/cycle while out_ready = 1.
- Handshake:
  - A pop happens when out_valid && out_ready.
  - out_pc and out_instr are stable while out_valid=1 and out_ready=0.
- Redirect (redirect_valid = 1 in cycle r):
  - In cycle r, imem_addr = {redirect_pc[31:2], 2'b00} combinationally, and it is issued (credit forced true).
  - pc <= that address + 4.
  - All in-flight valid bits are cleared, except the new stage-0 entry.
  - The queue is flushed. Any pop in cycle r is ignored, and out_valid is 0 in cycle r+1.
  - A word returning in cycle r from an older request is dropped.
  - Back-to-back redirects: the newest one wins.
- Full queue: no push can overflow, because the credit rule guarantees space.
- Empty queue: out_valid = 0, and out_pc/out_instr hold their last values.
- Simultaneous push and pop on a full queue is legal; the count is unchanged.
- Reset mid-operation: everything is discarded and fetch restarts at RESET_PC. No partial queue entries survive.

Decomposition:
- Shared package fetch_pkg:
  - XLEN = 32; ILEN = 32.
  - INSTR_NOP = 32'h0000_0013.
  - Typedef fetch_entry_t = {pc[31:0], instr[31:0]}.
- One sub-module: fetch_fifo.
  - Parameterised by depth, entry fetch_entry_t.
  - Push, pop, flush, count, full, empty outputs.
  - Read pointer selects the head combinationally.
  - Flush takes priority over push and pop.
- The rest (PC register, in-flight shift register, credit logic) lives in fetch_unit.

Test Plan:
- Reset release, out_ready=1, imem preloaded with word i at address 4i:
  - imem_addr = 0,4,8,… one per cycle.
  - out_valid rises in cycle 3 with out_pc=0.
  - Then one instruction per cycle, in order, with no gaps.
- Backpressure: hold out_ready=0 from cycle 0.
  - Queue fills to 4 entries (PCs 0x0–0xC).
  - imem_addr stalls at 0x10.
  - Release out_ready: PCs 0x0,0x4,… continue with no duplicate or skip.
- Redirect mid-stream: redirect_pc=0x0000_0103 in cycle 10.
  - imem_addr=0x100 in that cycle.
  - out_valid=0 in cycle 11.
  - Next accepted out_pc = 0x100; no pre-redirect PC appears afterward.
- Redirect and pop in the same cycle:
  - The head is not counted as consumed, and the queue is flushed.
  - Next three outputs are from the target, e.g. 0x200, 0x204, 0x208.
- PC wrap: redirect to 0xFFFF_FFF8.
  - Outputs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Reset asserted mid-stream with the queue partially full:
  - out_valid drops immediately (asynchronous).
  - After release, the sequence restarts at RESET_PC with no stale entries.
